// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared cpu constants for the instruction-fetch stage
package if_stage_pkg;

    localparam int                 INSTR_W    = 32;
    localparam logic [INSTR_W-1:0] HALT_INSTR = 32'hFFFF_FFFF;
    localparam logic [INSTR_W-1:0] NOP_INSTR  = 32'h0000_0000;

endpackage

// File: rtl/if_stage_instr_mem.sv
// rtl/if_stage_instr_mem.sv - instruction word array, sync write, combinational read
//   i_clk             clock
//   i_we              write strobe
//   i_waddr/i_wdata   write word index and data
//   i_raddr           read word index
//   o_rdata           read data (old contents on a same-cycle write)
module if_stage_instr_mem
    import if_stage_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int AW        = 8
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [INSTR_W-1:0] i_wdata,
    input  logic [AW-1:0]      i_raddr,
    output logic [INSTR_W-1:0] o_rdata
);

    logic [INSTR_W-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch with IF/ID register, halt detect and byte loader
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_pc, i_pc4             current PC (byte address) and PC+4
//   i_stall, i_flush        hold / squash the IF/ID register
//   i_load_en/byte/clear    byte-serial memory loader
//   o_instr, o_pc4, o_valid IF/ID register
//   o_halt                  sticky halt flag
//   o_load_words, o_load_full  loader progress
module if_stage
#(
    parameter int          MEM_DEPTH  = 256,
    parameter logic [31:0] HALT_INSTR = if_stage_pkg::HALT_INSTR
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [31:0]                i_pc,
    input  logic [31:0]                i_pc4,
    input  logic                       i_stall,
    input  logic                       i_flush,
    input  logic                       i_load_en,
    input  logic [7:0]                 i_load_byte,
    input  logic                       i_load_clear,
    output logic [31:0]                o_instr,
    output logic [31:0]                o_pc4,
    output logic                       o_valid,
    output logic                       o_halt,
    output logic [$clog2(MEM_DEPTH):0] o_load_words,
    output logic                       o_load_full
);
    import if_stage_pkg::*;

    localparam int AW = $clog2(MEM_DEPTH);

    // Loader state
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [23:0]        asm_q, asm_d;
    logic [AW:0]        ptr_q, ptr_d;
    logic               load_full;
    logic               mem_we;
    logic [INSTR_W-1:0] mem_wdata;

    // Fetch / IF-ID state
    logic [INSTR_W-1:0] mem_rdata, fetch_word;
    logic               pc_oor;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [31:0]        pc4_q, pc4_d;
    logic               valid_q, valid_d;
    logic               halt_q, halt_d;

    // The pointer's top bit is set exactly when all MEM_DEPTH words are written.
    assign load_full = ptr_q[AW];

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        ptr_d      = ptr_q;
        mem_we     = 1'b0;
        mem_wdata  = {asm_q, i_load_byte};
        if (i_load_clear) begin
            byte_cnt_d = 2'd0;
            ptr_d      = '0;
        end else if (i_load_en && !load_full) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
                2'd0: asm_d[23:16] = i_load_byte;
                2'd1: asm_d[15:8]  = i_load_byte;
                2'd2: asm_d[7:0]   = i_load_byte;
                default: begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                end
            endcase
        end
    end

    if_stage_instr_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (mem_we && !i_reset),
        .i_waddr (ptr_q[AW-1:0]),
        .i_wdata (mem_wdata),
        .i_raddr (i_pc[AW+1:2]),
        .o_rdata (mem_rdata)
    );

    // Any PC bit above the memory range fetches a NOP instead of aliasing.
    assign pc_oor     = |i_pc[31:AW+2];
    assign fetch_word = pc_oor ? NOP_INSTR : mem_rdata;

    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        halt_d  = halt_q;
        if (i_flush) begin
            instr_d = NOP_INSTR;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (!(i_stall || halt_q)) begin
            instr_d = fetch_word;
            pc4_d   = i_pc4;
            valid_d = 1'b1;
            if (fetch_word == HALT_INSTR) begin
                halt_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            byte_cnt_q <= 2'd0;
            asm_q      <= '0;
            ptr_q      <= '0;
            instr_q    <= '0;
            pc4_q      <= '0;
            valid_q    <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            ptr_q      <= ptr_d;
            instr_q    <= instr_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
            halt_q     <= halt_d;
        end
    end

    assign o_instr      = instr_q;
    assign o_pc4        = pc4_q;
    assign o_valid      = valid_q;
    assign o_halt       = halt_q;
    assign o_load_words = ptr_q;
    assign o_load_full  = load_full;

endmodule
